// File: rtl/life_step_scheduler.sv
// Paces Game-of-Life generations: issues a one-cycle enable per frame
// interval in RUNNING, or a single enable on request while paused.
//
// Ports:
//   clock          : system clock, all logic on posedge
//   reset_n        : synchronous active-low reset
//   frame_tick     : one-cycle pulse at start of vertical blank
//   run_toggle     : one-cycle pulse, toggles run/pause
//   step           : one-cycle pulse, requests one generation while paused
//   speed[2:0]     : one generation every 2^speed frames
//   pointer_select : high while a cell is being edited; blocks firing
//   enable         : registered one-cycle advance pulse
//   running        : high while in RUNNING
//   generation     : count of enable pulses issued (wraps)
module life_step_scheduler #(
  parameter bit AUTO_RUN  = 1'b0,
  parameter int GEN_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 frame_tick,
  input  logic                 run_toggle,
  input  logic                 step,
  input  logic [2:0]           speed,
  input  logic                 pointer_select,
  output logic                 enable,
  output logic                 running,
  output logic [GEN_WIDTH-1:0] generation
);

  typedef enum logic [1:0] {
    PAUSED     = 2'd0,
    RUNNING    = 2'd1,
    STEP_ARMED = 2'd2
  } state_e;

  localparam state_e RST_STATE = AUTO_RUN ? RUNNING : PAUSED;

  state_e               state_q, state_d;
  logic [7:0]           fcnt_q, fcnt_d;
  logic                 enable_q, enable_d;
  logic                 running_q, running_d;
  logic [GEN_WIDTH-1:0] gen_q, gen_d;
  logic [7:0]           term;
  logic                 tick_ok;

  // Terminal count (2^speed)-1 taken from speed as it stands this cycle.
  assign term    = ~(8'hFF << speed);
  assign tick_ok = frame_tick & ~pointer_select;

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    enable_d = 1'b0;
    if (run_toggle) begin
      // Toggle wins over step and over any fire in this cycle.
      state_d = (state_q == RUNNING) ? PAUSED : RUNNING;
      fcnt_d  = 8'd0;
    end else begin
      unique case (state_q)
        PAUSED: begin
          if (step) begin
            state_d = STEP_ARMED;
          end
        end
        RUNNING: begin
          if (tick_ok) begin
            // >= also catches speed lowered below the current count.
            if (fcnt_q >= term) begin
              enable_d = 1'b1;
              fcnt_d   = 8'd0;
            end else begin
              fcnt_d = fcnt_q + 8'd1;
            end
          end
        end
        STEP_ARMED: begin
          if (tick_ok) begin
            enable_d = 1'b1;
            state_d  = PAUSED;
          end
        end
        default: begin
          state_d = RST_STATE;
          fcnt_d  = 8'd0;
        end
      endcase
    end
    running_d = (state_d == RUNNING);
    gen_d     = enable_d ? gen_q + GEN_WIDTH'(1) : gen_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= RST_STATE;
      fcnt_q    <= 8'd0;
      enable_q  <= 1'b0;
      running_q <= AUTO_RUN;
      gen_q     <= '0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      enable_q  <= enable_d;
      running_q <= running_d;
      gen_q     <= gen_d;
    end
  end

  assign enable     = enable_q;
  assign running    = running_q;
  assign generation = gen_q;

endmodule

// File: tb/tb_life_step_scheduler.sv
// Directed bench for life_step_scheduler.
// Main DUT uses GEN_WIDTH=4 so wrap is reachable; second DUT checks AUTO_RUN.
module tb_life_step_scheduler;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       frame_tick = 1'b0;
  logic       run_toggle = 1'b0;
  logic       step = 1'b0;
  logic [2:0] speed = 3'd0;
  logic       pointer_select = 1'b0;
  logic       enable, running;
  logic [3:0] generation;
  logic       enable_a, running_a;
  logic [7:0] generation_a;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  life_step_scheduler #(.AUTO_RUN(1'b0), .GEN_WIDTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .frame_tick(frame_tick),
    .run_toggle(run_toggle), .step(step), .speed(speed),
    .pointer_select(pointer_select), .enable(enable),
    .running(running), .generation(generation)
  );

  life_step_scheduler #(.AUTO_RUN(1'b1), .GEN_WIDTH(8)) dut_auto (
    .clock(clock), .reset_n(reset_n), .frame_tick(frame_tick),
    .run_toggle(run_toggle), .step(step), .speed(speed),
    .pointer_select(pointer_select), .enable(enable_a),
    .running(running_a), .generation(generation_a)
  );

  // One clock cycle with the given pulses; sampled 1ns after the edge.
  task automatic cyc(input logic ft, input logic rt, input logic st,
                     input logic ps, input logic rn);
    @(negedge clock);
    frame_tick     = ft;
    run_toggle     = rt;
    step           = st;
    pointer_select = ps;
    reset_n        = rn;
    @(posedge clock);
    #1;
    frame_tick     = 1'b0;
    run_toggle     = 1'b0;
    step           = 1'b0;
    pointer_select = 1'b0;
    reset_n        = 1'b1;
  endtask

  task automatic test_reset;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (enable !== 1'b0) begin
      errors++; $display("FAIL reset_enable: got %b expected 0", enable);
    end
    checks++;
    if (running !== 1'b0) begin
      errors++; $display("FAIL reset_running: got %b expected 0", running);
    end
    checks++;
    if (generation !== 4'd0) begin
      errors++; $display("FAIL reset_gen: got %0d expected 0", generation);
    end
    checks++;
    if (running_a !== 1'b1) begin
      errors++; $display("FAIL reset_autorun: got %b expected 1", running_a);
    end
    checks++;
    if (generation_a !== 8'd0) begin
      errors++; $display("FAIL reset_auto_gen: got %0d expected 0", generation_a);
    end
  endtask

  task automatic test_step;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (running !== 1'b0 || enable !== 1'b0) begin
      errors++; $display("FAIL step_arm: got run=%b en=%b expected 0 0", running, enable);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (enable !== 1'b1 || generation !== 4'd1) begin
      errors++; $display("FAIL step_fire: got en=%b gen=%0d expected 1 1", enable, generation);
    end
    checks++;
    if (running !== 1'b0) begin
      errors++; $display("FAIL step_running: got %b expected 0", running);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (enable !== 1'b0 || generation !== 4'd1) begin
      errors++; $display("FAIL step_width: got en=%b gen=%0d expected 0 1", enable, generation);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (enable !== 1'b0 || generation !== 4'd1) begin
      errors++; $display("FAIL paused_tick: got en=%b gen=%0d expected 0 1", enable, generation);
    end
  endtask

  task automatic test_step_pointer;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (enable !== 1'b0) begin
      errors++; $display("FAIL armed_blocked: got %b expected 0", enable);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (enable !== 1'b1 || generation !== 4'd2) begin
      errors++; $display("FAIL armed_retry: got en=%b gen=%0d expected 1 2", enable, generation);
    end
  endtask

  task automatic test_run_speed;
    logic exp;
    speed = 3'd2;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (running !== 1'b1) begin
      errors++; $display("FAIL run_enter: got %b expected 1", running);
    end
    for (int i = 1; i <= 8; i++) begin
      exp = (i == 4 || i == 8);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (enable !== exp) begin
        errors++; $display("FAIL speed2_tick%0d: got %b expected %b", i, enable, exp);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    checks++;
    if (generation !== 4'd4 || running !== 1'b1) begin
      errors++; $display("FAIL speed2_end: got gen=%0d run=%b expected 4 1", generation, running);
    end
  endtask

  task automatic test_pointer;
    speed = 3'd0;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (enable !== 1'b0) begin
      errors++; $display("FAIL ptr_blocked: got %b expected 0", enable);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (enable !== 1'b1 || generation !== 4'd5) begin
      errors++; $display("FAIL ptr_retry: got en=%b gen=%0d expected 1 5", enable, generation);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_speed_lower;
    int fired;
    speed = 3'd3;
    fired = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      if (enable) fired++;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    checks++;
    if (fired !== 0) begin
      errors++; $display("FAIL speed3_count: got %0d fires expected 0", fired);
    end
    speed = 3'd1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (enable !== 1'b1 || generation !== 4'd6) begin
      errors++; $display("FAIL speed_lower: got en=%b gen=%0d expected 1 6", enable, generation);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (enable !== 1'b0) begin
      errors++; $display("FAIL fcnt_cleared: got %b expected 0", enable);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (enable !== 1'b1 || generation !== 4'd7) begin
      errors++; $display("FAIL speed1_fire: got en=%b gen=%0d expected 1 7", enable, generation);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_toggle_tick;
    speed = 3'd0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (enable !== 1'b0 || running !== 1'b0) begin
      errors++; $display("FAIL toggle_tick: got en=%b run=%b expected 0 0", enable, running);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (enable !== 1'b0 || generation !== 4'd7) begin
      errors++; $display("FAIL toggle_paused: got en=%b gen=%0d expected 0 7", enable, generation);
    end
  endtask

  task automatic test_step_toggle;
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (running !== 1'b1) begin
      errors++; $display("FAIL step_toggle_run: got %b expected 1", running);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (running !== 1'b0) begin
      errors++; $display("FAIL step_toggle_pause: got %b expected 0", running);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (enable !== 1'b0) begin
      errors++; $display("FAIL step_not_queued: got %b expected 0", enable);
    end
  endtask

  task automatic test_reset_armed;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (generation !== 4'd0 || running !== 1'b0) begin
      errors++; $display("FAIL armed_reset: got gen=%0d run=%b expected 0 0", generation, running);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (enable !== 1'b0) begin
      errors++; $display("FAIL armed_discard: got %b expected 0", enable);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (enable !== 1'b0 || generation !== 4'd0) begin
      errors++; $display("FAIL reset_suppress: got en=%b gen=%0d expected 0 0", enable, generation);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (enable !== 1'b0) begin
      errors++; $display("FAIL reset_suppress_late: got %b expected 0", enable);
    end
  endtask

  task automatic test_wrap;
    speed = 3'd0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (i == 15) begin
        checks++;
        if (generation !== 4'd15) begin
          errors++; $display("FAIL wrap_15: got %0d expected 15", generation);
        end
      end
    end
    checks++;
    if (generation !== 4'd0) begin
      errors++; $display("FAIL wrap_0: got %0d expected 0", generation);
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_step_pointer();
    test_run_speed();
    test_pointer();
    test_speed_lower();
    test_toggle_tick();
    test_step_toggle();
    test_reset_armed();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/life_step_scheduler.md
LIFE_STEP_SCHEDULER -- requirements
Module: life_step_scheduler

Interface
REQ-001 SHALL have parameter AUTO_RUN, default 0, meaning 1 = leave reset in RUNNING, 0 = leave reset in PAUSED.
REQ-002 SHALL have parameter GEN_WIDTH, default 16, meaning width of the generation counter.
REQ-003 SHALL have port clock  input  1  the single system clock; all logic on posedge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port frame_tick  input  1  one-cycle pulse at the start of vertical blank.
REQ-006 SHALL have port run_toggle  input  1  one-cycle pulse that toggles run/pause.
REQ-007 SHALL have port step  input  1  one-cycle pulse that requests a single generation while paused.
REQ-008 SHALL have port speed  input  3  rate selector; one generation every 2^speed frames.
REQ-009 SHALL have port pointer_select  input  1  high while the user edits a cell; blocks advancing.
REQ-010 SHALL have port enable  output  1  registered one-cycle pulse that advances the life grid one generation.
REQ-011 SHALL have port running  output  1  high in RUNNING state.
REQ-012 SHALL have port generation  output  GEN_WIDTH  count of enable pulses issued.

Function
REQ-013 SHALL implement three states: PAUSED, RUNNING, STEP_ARMED.
REQ-014 SHALL keep an internal 8-bit frame counter fcnt; terminal value T = (1 << speed) - 1, with speed sampled on every frame_tick.
REQ-015 On run_toggle: PAUSED->RUNNING, STEP_ARMED->RUNNING (pending step cancelled), RUNNING->PAUSED; fcnt cleared to 0 on any toggle.
REQ-016 On step: PAUSED->STEP_ARMED; step ignored in RUNNING and STEP_ARMED (no queuing).
REQ-017 Same-cycle run_toggle and step: run_toggle wins, step dropped.
REQ-018 RUNNING, frame_tick with fcnt < T: fcnt increments, no enable.
REQ-019 RUNNING, frame_tick with fcnt >= T (covers speed lowered mid-count): fire, fcnt <= 0.
REQ-020 STEP_ARMED, frame_tick: fire, state -> PAUSED.
REQ-021 "Fire" = enable high exactly the cycle after the frame_tick cycle (latency 1, registered), width exactly one cycle.
REQ-022 Fire blocked if pointer_select is high in the frame_tick cycle: no enable, fcnt holds (RUNNING) or state stays STEP_ARMED; retry on the next frame_tick.
REQ-023 frame_tick in PAUSED: no effect; fcnt holds.
REQ-024 run_toggle coincident with a frame_tick: the toggle takes effect, no fire in that cycle.
REQ-025 generation increments by 1 in the same cycle enable is high, wrapping from 2^GEN_WIDTH-1 to 0.
REQ-026 enable never high in consecutive cycles; at most one enable per frame_tick.
REQ-027 running is registered and reflects the state after each update (high only in RUNNING).
REQ-028 Inputs are treated as already synchronous to clock; no internal edge detection.

Reset
REQ-029 reset_n low at a posedge SHALL set: state to RUNNING if AUTO_RUN=1 else PAUSED; enable 0; generation 0; fcnt 0; running = AUTO_RUN.
REQ-030 Reset SHALL override all inputs in the same cycle, and a pending STEP_ARMED SHALL be discarded.
REQ-031 An enable pulse scheduled for the cycle after reset assertion SHALL be suppressed.

Verification
REQ-032 AUTO_RUN=0: reset, then step, then frame_tick -> enable high for 1 cycle, generation=1, state PAUSED, running=0.
REQ-033 run_toggle, speed=2, 8 frame_ticks -> enable after the 4th and 8th ticks only, generation=2, running=1.
REQ-034 RUNNING, speed=0, pointer_select high during a tick -> no enable; next tick with pointer_select low -> enable.
REQ-035 RUNNING, speed=3, fcnt=5, speed set to 1, then tick -> enable (fcnt>=T), fcnt=0.
REQ-036 Same-cycle step and run_toggle from PAUSED -> RUNNING, no step; reset asserted while STEP_ARMED -> next tick gives no enable.
REQ-037 GEN_WIDTH=4, 16 fired generations -> generation wraps to 0.
